// File: rtl/eco32f_divider_pkg.sv
// Shared types and constants for the eco32f iterative divider.
// ECO32F_DIV_RADIX4_EN selects two restoring steps per cycle (16-cycle RUN).
package eco32f_divider_pkg;

  typedef enum logic [1:0] {
    ECO32F_DIV_IDLE = 2'd0,
    ECO32F_DIV_RUN  = 2'd1,
    ECO32F_DIV_DONE = 2'd2
  } div_state_e;

  localparam int ECO32F_DIV_CNT_W = 5;

`ifdef ECO32F_DIV_RADIX4_EN
  localparam int ECO32F_DIV_CYCLES = 16;
`else
  localparam int ECO32F_DIV_CYCLES = 32;
`endif

  // Counter is loaded with CYCLES-1 so that DONE follows the cycle where it reads zero.
  localparam logic [ECO32F_DIV_CNT_W-1:0] ECO32F_DIV_CNT_INIT =
    ECO32F_DIV_CNT_W'(ECO32F_DIV_CYCLES - 1);

  function automatic logic [31:0] div_magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] div_apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/eco32f_divider_if.sv
// EX-stage request and result signals between the pipeline and the divider.
// Shared by both ECO32F_DIV_RADIX4_EN build variants.
interface eco32f_divider_if;
  logic        ex_op_div;
  logic        ex_op_rem;
  logic        ex_signed_div;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic        ex_stall;
  logic        ex_flush;
  logic        div_stall;
  logic        div_valid;
  logic [31:0] div_result;
  logic        div_exc_zero;

  modport master (
    output ex_op_div, ex_op_rem, ex_signed_div, ex_op_a, ex_op_b, ex_stall, ex_flush,
    input  div_stall, div_valid, div_result, div_exc_zero
  );

  modport slave (
    input  ex_op_div, ex_op_rem, ex_signed_div, ex_op_a, ex_op_b, ex_stall, ex_flush,
    output div_stall, div_valid, div_result, div_exc_zero
  );
endinterface

// File: rtl/eco32f_div_step.sv
// One combinational restoring-division step over the {rem,quot} pair.
// Chained twice by the divider when ECO32F_DIV_RADIX4_EN is defined.
module eco32f_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] divisor,
  output logic [31:0] rem_nxt,
  output logic [31:0] quot_nxt
);

  logic [32:0] shifted_s;
  logic [33:0] diff_s;

  // Shift in the next dividend bit and trial-subtract; bit 33 is the borrow.
  always_comb begin
    shifted_s = {rem, quot[31]};
    diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
    if (diff_s[33]) begin
      rem_nxt  = shifted_s[31:0];
      quot_nxt = {quot[30:0], 1'b0};
    end else begin
      rem_nxt  = diff_s[31:0];
      quot_nxt = {quot[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/eco32f_divider.sv
// Multi-cycle signed/unsigned divider for the EX stage with IDLE/RUN/DONE sequencing.
// Define ECO32F_DIV_RADIX4_EN to retire two quotient bits per cycle.
module eco32f_divider
  import eco32f_divider_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  eco32f_divider_if.slave    bus
);

  div_state_e                  state_r, state_s;
  logic [ECO32F_DIV_CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]                 rem_r, rem_s;
  logic [31:0]                 quot_r, quot_s;
  logic [31:0]                 divisor_r, divisor_s;
  logic                        op_rem_r, op_rem_s;
  logic                        neg_q_r, neg_q_s;
  logic                        neg_r_r, neg_r_s;
  logic                        valid_r, valid_s;
  logic [31:0]                 result_r, result_s;
  logic                        exc_zero_r, exc_zero_s;
  logic                        stall_s;
  logic                        start_s;
  logic [31:0]                 step_rem_s, step_quot_s;
  logic [31:0]                 final_s;

`ifdef ECO32F_DIV_RADIX4_EN
  logic [31:0] mid_rem_s, mid_quot_s;

  eco32f_div_step u_step0 (
    .rem(rem_r), .quot(quot_r), .divisor(divisor_r),
    .rem_nxt(mid_rem_s), .quot_nxt(mid_quot_s)
  );
  eco32f_div_step u_step1 (
    .rem(mid_rem_s), .quot(mid_quot_s), .divisor(divisor_r),
    .rem_nxt(step_rem_s), .quot_nxt(step_quot_s)
  );
`else
  eco32f_div_step u_step0 (
    .rem(rem_r), .quot(quot_r), .divisor(divisor_r),
    .rem_nxt(step_rem_s), .quot_nxt(step_quot_s)
  );
`endif

  assign start_s = bus.ex_op_div | bus.ex_op_rem;
  // Result of the last step, sign-corrected, so DONE can register it directly.
  assign final_s = op_rem_r ? div_apply_sign(step_rem_s, neg_r_r)
                            : div_apply_sign(step_quot_s, neg_q_r);

  // Next-state, datapath and stall decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    rem_s      = rem_r;
    quot_s     = quot_r;
    divisor_s  = divisor_r;
    op_rem_s   = op_rem_r;
    neg_q_s    = neg_q_r;
    neg_r_s    = neg_r_r;
    valid_s    = 1'b0;
    result_s   = result_r;
    exc_zero_s = 1'b0;
    stall_s    = 1'b0;
    case (state_r)
      ECO32F_DIV_IDLE: begin
        if (start_s && !bus.ex_flush) begin
          stall_s   = 1'b1;
          op_rem_s  = bus.ex_op_rem;
          neg_q_s   = bus.ex_signed_div & (bus.ex_op_a[31] ^ bus.ex_op_b[31]);
          neg_r_s   = bus.ex_signed_div & bus.ex_op_a[31];
          quot_s    = div_magnitude(bus.ex_op_a, bus.ex_signed_div);
          rem_s     = 32'd0;
          divisor_s = div_magnitude(bus.ex_op_b, bus.ex_signed_div);
          cnt_s     = ECO32F_DIV_CNT_INIT;
          if (bus.ex_op_b == 32'd0) begin
            state_s    = ECO32F_DIV_DONE;
            valid_s    = 1'b1;
            result_s   = 32'd0;
            exc_zero_s = 1'b1;
          end else begin
            state_s = ECO32F_DIV_RUN;
          end
        end else begin
          state_s = ECO32F_DIV_IDLE;
        end
      end
      ECO32F_DIV_RUN: begin
        if (bus.ex_flush) begin
          state_s = ECO32F_DIV_IDLE;
        end else begin
          stall_s = 1'b1;
          rem_s   = step_rem_s;
          quot_s  = step_quot_s;
          if (cnt_r == {ECO32F_DIV_CNT_W{1'b0}}) begin
            state_s  = ECO32F_DIV_DONE;
            valid_s  = 1'b1;
            result_s = final_s;
          end else begin
            cnt_s = cnt_r - ECO32F_DIV_CNT_W'(1);
          end
        end
      end
      ECO32F_DIV_DONE: begin
        // The op still visible in EX here is the finished instruction, not a new one.
        if (bus.ex_flush || !bus.ex_stall) begin
          state_s = ECO32F_DIV_IDLE;
        end else begin
          valid_s    = 1'b1;
          exc_zero_s = exc_zero_r;
        end
      end
      default: begin
        state_s = ECO32F_DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ECO32F_DIV_IDLE;
      cnt_r      <= {ECO32F_DIV_CNT_W{1'b0}};
      rem_r      <= 32'd0;
      quot_r     <= 32'd0;
      divisor_r  <= 32'd0;
      op_rem_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      valid_r    <= 1'b0;
      result_r   <= 32'd0;
      exc_zero_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rem_r      <= rem_s;
      quot_r     <= quot_s;
      divisor_r  <= divisor_s;
      op_rem_r   <= op_rem_s;
      neg_q_r    <= neg_q_s;
      neg_r_r    <= neg_r_s;
      valid_r    <= valid_s;
      result_r   <= result_s;
      exc_zero_r <= exc_zero_s;
    end
  end

  assign bus.div_stall    = stall_s;
  assign bus.div_valid    = valid_r;
  assign bus.div_result   = result_r;
  assign bus.div_exc_zero = exc_zero_r;

endmodule

// File: tb/tb_eco32f_divider.sv
// Directed self-checking bench for eco32f_divider; expected latency follows
// ECO32F_DIV_RADIX4_EN (17 cycles when defined, 33 otherwise).
module tb_eco32f_divider;

`ifdef ECO32F_DIV_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  eco32f_divider_if dif ();

  eco32f_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_ops();
    dif.ex_op_div     = 1'b0;
    dif.ex_op_rem     = 1'b0;
    dif.ex_signed_div = 1'b0;
    dif.ex_op_a       = 32'd0;
    dif.ex_op_b       = 32'd0;
  endtask

  // Presents one op at a negedge, counts stall cycles until div_valid, then retires it.
  task automatic run_op(input string tag, input logic op_div, input logic op_rem,
                        input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
    int cyc;
    int stalls;
    @(negedge clk);
    dif.ex_op_div     = op_div;
    dif.ex_op_rem     = op_rem;
    dif.ex_signed_div = sgn;
    dif.ex_op_a       = a;
    dif.ex_op_b       = b;
    #1;
    cyc    = 0;
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      if (dif.div_valid) break;
      if (dif.div_stall) stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"},    32'(cyc),              32'(exp_lat));
    check({tag, "_stalls"}, 32'(stalls),           32'(exp_lat));
    check({tag, "_vstall"}, {31'd0, dif.div_stall}, 32'd0);
    check({tag, "_res"},    dif.div_result,         exp_res);
    check({tag, "_exc"},    {31'd0, dif.div_exc_zero}, {31'd0, exp_exc});
    @(negedge clk);
    clear_ops();
    #1;
    check({tag, "_idle"},   {31'd0, dif.div_valid}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    dif.ex_stall = 1'b0;
    dif.ex_flush = 1'b0;
    clear_ops();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall",  {31'd0, dif.div_stall},    32'd0);
    check("rst_valid",  {31'd0, dif.div_valid},    32'd0);
    check("rst_result", dif.div_result,            32'd0);
    check("rst_exc",    {31'd0, dif.div_exc_zero}, 32'd0);

    run_op("divu_100_7",  1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0, LAT);
    run_op("remu_100_7",  1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 32'd2,  1'b0, LAT);
    run_op("rem_m7_2",    1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, LAT);
    run_op("div_m7_2",    1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, LAT);
    run_op("div_5_0",     1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 1);
    run_op("div_min_m1",  1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT);
    run_op("rem_min_m1",  1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT);

    // Flush in the tenth RUN cycle: stall drops at once, block idles next cycle.
    @(negedge clk);
    dif.ex_op_div = 1'b1;
    dif.ex_op_a   = 32'd1000;
    dif.ex_op_b   = 32'd3;
    #1;
    check("fl_start_stall", {31'd0, dif.div_stall}, 32'd1);
    repeat (10) @(negedge clk);
    #1;
    check("fl_run10_stall", {31'd0, dif.div_stall}, 32'd1);
    dif.ex_flush = 1'b1;
    #1;
    check("fl_flush_stall", {31'd0, dif.div_stall}, 32'd0);
    @(negedge clk);
    dif.ex_flush = 1'b0;
    clear_ops();
    #1;
    check("fl_idle_stall", {31'd0, dif.div_stall}, 32'd0);
    check("fl_idle_valid", {31'd0, dif.div_valid}, 32'd0);
    run_op("divu_9_3", 1'b1, 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 1'b0, LAT);

    // Hold DONE with ex_stall for five cycles.
    @(negedge clk);
    dif.ex_op_div = 1'b1;
    dif.ex_op_a   = 32'd50;
    dif.ex_op_b   = 32'd6;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (dif.div_valid) break;
      @(negedge clk);
      #1;
    end
    dif.ex_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",  {31'd0, dif.div_valid}, 32'd1);
      check("hold_result", dif.div_result,         32'd8);
      check("hold_stall",  {31'd0, dif.div_stall}, 32'd0);
      @(negedge clk);
      #1;
    end
    dif.ex_stall = 1'b0;
    #1;
    check("hold_last_valid",  {31'd0, dif.div_valid}, 32'd1);
    check("hold_last_result", dif.div_result,         32'd8);
    @(negedge clk);
    clear_ops();
    #1;
    check("hold_idle_valid", {31'd0, dif.div_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
